// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with a power-on reset sequencer.
// Each channel emits a one-cycle enable pulse and a near-50% square wave per period.
module clock_divider_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 12,
  parameter int unsigned RESET_HOLD  = 255
) (
  input  logic                    osc48m,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_value,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       div_pending,
  output logic                    rst_out
);

  localparam int unsigned HOLD_W = 16;
  localparam int unsigned HALF_W = DIV_W + 1;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  seq_state_t        state;
  seq_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              rst_out_next;

  // Reset sequencer state register.
  always_ff @(posedge osc48m or negedge reset) begin
    if (!reset) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      rst_out  <= 1'b1;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      rst_out  <= rst_out_next;
    end
  end

  // Count hold cycles; drop rst_out on the edge the count reaches RESET_HOLD.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    rst_out_next  = rst_out;
    case (state)
      ST_HOLD: begin
        hold_cnt_next = hold_cnt + HOLD_W'(1);
        rst_out_next  = 1'b1;
        if (hold_cnt_next == HOLD_W'(RESET_HOLD)) begin
          state_next   = ST_RUN;
          rst_out_next = 1'b0;
        end
      end
      ST_RUN: begin
        rst_out_next = 1'b0;
      end
      default: begin
        state_next   = ST_HOLD;
        rst_out_next = 1'b1;
      end
    endcase
  end

  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  pend;
    logic              en_q;
    logic              out_q;
    logic              pending_q;
    logic [DIV_W-1:0]  cnt_next;
    logic [DIV_W-1:0]  div_next;
    logic [DIV_W-1:0]  pend_next;
    logic              en_next;
    logic              out_next;
    logic              pending_next;
    logic [DIV_W-1:0]  d_eff;
    logic [HALF_W-1:0] half;
    logic [DIV_W-1:0]  load_val;
    logic              run;
    logic              tc;
    logic              sync_hit;

    assign load_val       = div_value[i*DIV_W +: DIV_W];
    assign clk_en[i]      = en_q;
    assign clk_out[i]     = out_q;
    assign div_pending[i] = pending_q;

    // Channel next-state: counter wrap, divisor hand-over and output shaping.
    always_comb begin
      d_eff        = (div == '0) ? DIV_W'(1) : div;
      half         = ({1'b0, d_eff} + HALF_W'(1)) >> 1;
      run          = ch_enable[i] & ~rst_out;
      tc           = run & (cnt == (d_eff - DIV_W'(1)));
      sync_hit     = run & sync;
      cnt_next     = cnt;
      div_next     = div;
      pend_next    = pend;
      pending_next = pending_q;
      en_next      = tc;
      out_next     = run & ({1'b0, cnt} < half);

      if (!run || sync_hit || tc) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + DIV_W'(1);
      end

      if (div_load[i]) begin
        pend_next    = load_val;
        pending_next = 1'b1;
      end

      // Period boundary (or sync): a same-cycle load takes priority over the held one.
      if (sync_hit || tc) begin
        if (div_load[i]) begin
          div_next     = load_val;
          pending_next = 1'b0;
        end else if (pending_q) begin
          div_next     = pend;
          pending_next = 1'b0;
        end
      end else if (!run && pending_q) begin
        div_next     = pend;
        pending_next = div_load[i];
      end
    end

    // Channel registers.
    always_ff @(posedge osc48m or negedge reset) begin
      if (!reset) begin
        cnt       <= '0;
        div       <= DIV_W'(DEFAULT_DIV);
        pend      <= DIV_W'(DEFAULT_DIV);
        en_q      <= 1'b0;
        out_q     <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        cnt       <= cnt_next;
        div       <= div_next;
        pend      <= pend_next;
        en_q      <= en_next;
        out_q     <= out_next;
        pending_q <= pending_next;
      end
    end
  end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised bank of NUM_CH independent programmable clock dividers, all running off the 48 MHz board oscillator.
- Each channel produces a one-cycle clock-enable pulse (`clk_en`) and a near-50% divided square wave (`clk_out`).
- Divisors can be changed at runtime without runt pulses, and a `sync` input phase-aligns all channels.
- Includes a power-on reset sequencer that holds `rst_out` for a programmable number of cycles; downstream logic uses it as its reset.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- DIV_W, 16, divisor width in bits.
- DEFAULT_DIV, 12, divisor loaded into every channel at reset (4 MHz enable from 48 MHz).
- RESET_HOLD, 255, `osc48m` cycles `rst_out` stays high after reset release (1..2^16-1).

Ports:
- osc48m  in  1  48 MHz source clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_enable  in  NUM_CH  per-channel run enable.
- div_load  in  NUM_CH  per-channel one-cycle strobe capturing `div_value`.
- div_value  in  NUM_CH*DIV_W  divisor for channel i at bits [i*DIV_W +: DIV_W].
- sync  in  1  one-cycle strobe restarting all channel counters.
- clk_en  out  NUM_CH  one-cycle pulse per divided period.
- clk_out  out  NUM_CH  divided square wave.
- div_pending  out  NUM_CH  loaded divisor not yet applied.
- rst_out  out  1  sequenced active-high reset for downstream logic.

Behaviour:
Reset (`reset`=0, asynchronous):
- `cnt[i]`=0; `div[i]`=`pend[i]`=DEFAULT_DIV.
- `clk_en`=0, `clk_out`=0, `div_pending`=0.
- `rst_out`=1; hold counter=0.
- Asserting reset mid-operation forces all of this immediately, with no pending update preserved.

Reset sequencer:
- After `reset` rises, the hold counter increments each cycle.
- `rst_out` falls on the edge where the counter reaches RESET_HOLD, then stays 0 until the next reset.

Channel run condition:
- Channel i runs only when `ch_enable[i]`=1 and `rst_out`=0.

Effective divisor:
- D = max(`div[i]`,1). Values 0 and 1 both mean divide-by-1.

Counter:
- Running: `cnt` increments each cycle, wrapping to 0 after D-1.
- Terminal count: `cnt`==D-1.

Outputs (registered, one cycle behind `cnt`):
- `clk_en[i]`=1 in the cycle after `cnt` is at terminal count.
- `clk_out[i]` = (`cnt` < ceil(D/2)), registered.
- D=1: `clk_en` and `clk_out` held at 1 while running.
- D=2: `clk_out` toggles each cycle. D=3: 2 cycles high, 1 low.
- Not running: `cnt` holds 0, `clk_en`=0, `clk_out`=0.
- On re-enable, the first `clk_en` arrives D cycles after enable.

Divisor update:
- `div_load[i]` writes `pend[i]` and sets `div_pending[i]`. Repeated loads before apply: last value wins.
- While running, `pend` is copied to `div` on the terminal-count cycle and `div_pending` clears. The new D applies from the next `cnt`=0, so there is no runt period.
- Load in the same cycle as terminal count: the new value is applied at that terminal count.
- Channel not running: `pend` is copied to `div` on the next cycle.

Sync:
- `sync`=1 sets every running channel's `cnt` to 0 next cycle and applies any pending divisor.
- `sync` overrides terminal-count wrap and the apply timing above. `clk_en` is not pulsed by `sync` itself.
- `sync` during `rst_out`=1 is ignored.

Width rules:
- `cnt` is DIV_W bits.
- ceil(D/2) is computed as (D+1)>>1 in DIV_W+1 bits, so D = 2^DIV_W-1 does not overflow.

Test Plan:
- Reset release, RESET_HOLD=255 -> `rst_out` high for exactly 255 cycles, then 0. All `clk_en`/`clk_out` 0 during hold.
- ch0 enabled, DEFAULT_DIV=12 -> `clk_en[0]` pulses every 12 cycles; `clk_out[0]` 6 high / 6 low; first pulse 12 cycles after enable.
- ch1 running D=12; `div_load` 5 at cnt=3, then 7 at cnt=8 -> `div_pending` high until terminal count, no runt, next period 7 cycles (4 high / 3 low).
- `div_value`=0 and =1 -> `clk_en` and `clk_out` constant 1; `div_value`=3 -> 2 high / 1 low pattern.
- Channels at D=4,6,8 free-running; `sync` pulse -> all `cnt`=0 next cycle; `clk_en` coincident every 24 cycles thereafter.
- Assert `reset` mid-period with a pending load -> outputs 0 and `rst_out`=1 asynchronously; after release all channels resume at DEFAULT_DIV.
